set_cmd_dispatch: RTL
=====================

SET_CMD_DISPATCH -- requirements
Module: set_cmd_dispatch

Interface
REQ-001 Parameter: FIFO_DEPTH, 4, command FIFO entries (power of 2, 2..16).
REQ-002 Parameter: TIMEOUT, 300, maximum cycles from en to set_valid before abort.
REQ-003 clk  in  1  single clock; all logic on rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 cmd_wr  in  1  host write strobe; one command per cycle.
REQ-006 cmd_central  in  24  three 4-bit x/y pairs, same packing as the SET central bus.
REQ-007 cmd_radius  in  12  three 4-bit radii.
REQ-008 cmd_mode  in  2  set operation.
REQ-009 cmd_full  out  1  FIFO full; a cmd_wr while full is dropped.
REQ-010 cmd_ovf  out  1  sticky; set by a dropped write, cleared only by rst.
REQ-011 en  out  1  one-cycle start pulse to the SET engine.
REQ-012 central / radius / mode  out  24/12/2  command presented to the SET engine.
REQ-013 set_valid  in  1  SET engine result strobe.
REQ-014 set_candidate  in  8  SET engine count, valid while set_valid=1.
REQ-015 res_valid  out  1  result available; held until accepted.
REQ-016 res_ready  in  1  consumer accept; transfer when res_valid&&res_ready.
REQ-017 res_candidate  out  8  captured count (0 on timeout).
REQ-018 res_tag  out  2  sequence number of the originating command.
REQ-019 res_err  out  1  result produced by timeout.

Function
REQ-020 FIFO SHALL store {central,radius,mode,tag} for each accepted write; tag is a 2-bit counter incremented per accepted write, wrapping 3->0.
REQ-021 cmd_full SHALL be high when occupancy==FIFO_DEPTH; write and pop in the same cycle while full SHALL pop only (write dropped, cmd_ovf set).
REQ-022 FSM states SHALL be IDLE, ISSUE, WAIT, HOLD.
REQ-023 IDLE->ISSUE when FIFO non-empty and res_valid==0; otherwise stay.
REQ-024 ISSUE: en=1 for exactly this cycle; central/radius/mode driven from the FIFO head; next state WAIT.
REQ-025 central/radius/mode SHALL stay stable from ISSUE until the FIFO pop (covers the engine's capture cycle after en).
REQ-026 WAIT: count cycles from 1; set_valid=1 -> capture set_candidate and tag, res_err=0, pop FIFO, res_valid=1 next cycle, ->HOLD.
REQ-027 WAIT: counter reaching TIMEOUT without set_valid -> res_candidate=0, res_err=1, pop, res_valid=1, ->HOLD.
REQ-028 set_valid outside WAIT SHALL be ignored.
REQ-029 HOLD: res_* stable until res_valid&&res_ready; then res_valid=0 next cycle, ->IDLE.
REQ-030 Minimum gap from a result accept to the next en SHALL be 2 cycles (HOLD->IDLE->ISSUE).
REQ-031 cmd_wr SHALL be accepted in every state, including the FIFO-pop cycle.
REQ-032 Timeout counter SHALL be 9 bits minimum, cleared on entry to WAIT, and never wrap.

Reset
REQ-033 rst high at a clock edge SHALL force: state IDLE; FIFO empty; tag counter 0; cmd_full=0, cmd_ovf=0, en=0, central=0, radius=0, mode=0, res_valid=0, res_candidate=0, res_tag=0, res_err=0.
REQ-034 rst mid-WAIT or mid-HOLD SHALL discard pending command and result; no en for at least 1 cycle after rst deasserts.

Verification
REQ-035 Write one cmd (central=0x440000, radius=0x200, mode=0) with a real SET engine -> one en pulse; res_valid with res_candidate=13, res_tag=0, res_err=0.
REQ-036 Write 4 cmds back to back with FIFO_DEPTH=4 and res_ready=1 -> cmd_full high after the 4th write; results in order with tags 0,1,2,3; a 5th write while full -> cmd_ovf=1.
REQ-037 Hold res_ready=0 for 50 cycles with 2 queued cmds -> res_* stable, no second en until accept, then en 2 cycles after accept.
REQ-038 Engine model that never asserts set_valid, TIMEOUT=300 -> res_valid exactly 300 cycles after en cycle +1, res_err=1, res_candidate=0.
REQ-039 Assert rst during WAIT -> all outputs at reset values next cycle; late set_valid from the engine produces no result.
REQ-040 Stray set_valid in IDLE with an empty FIFO -> res_valid stays 0.

Source files
------------

// File: rtl/set_cmd_dispatch_if.sv
// Host command, SET engine and result-consumer signals of the dispatcher.
// The slave modport is the dispatcher; the master modport is its environment.
interface set_cmd_dispatch_if;
  // host command write port
  logic        cmd_wr;
  logic [23:0] cmd_central;
  logic [11:0] cmd_radius;
  logic [1:0]  cmd_mode;
  logic        cmd_full;
  logic        cmd_ovf;
  // SET engine side
  logic        en;
  logic [23:0] central;
  logic [11:0] radius;
  logic [1:0]  mode;
  logic        set_valid;
  logic [7:0]  set_candidate;
  // result channel
  logic        res_valid;
  logic        res_ready;
  logic [7:0]  res_candidate;
  logic [1:0]  res_tag;
  logic        res_err;

  modport master (
    output cmd_wr, cmd_central, cmd_radius, cmd_mode,
    output set_valid, set_candidate, res_ready,
    input  cmd_full, cmd_ovf, en, central, radius, mode,
    input  res_valid, res_candidate, res_tag, res_err
  );

  modport slave (
    input  cmd_wr, cmd_central, cmd_radius, cmd_mode,
    input  set_valid, set_candidate, res_ready,
    output cmd_full, cmd_ovf, en, central, radius, mode,
    output res_valid, res_candidate, res_tag, res_err
  );
endinterface

// File: rtl/set_cmd_dispatch.sv
// Command dispatcher for a SET engine: queues host commands in a small FIFO,
// issues them one at a time, waits for the engine result (or a timeout) and
// holds the tagged result until the consumer accepts it.
module set_cmd_dispatch #(
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 300
) (
  input  logic              clk,
  input  logic              rst,
  set_cmd_dispatch_if.slave bus
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = ($clog2(TIMEOUT + 1) > 9) ? $clog2(TIMEOUT + 1) : 9;
  localparam int EW = 24 + 12 + 2 + 2;
  localparam logic [AW:0]   DEPTH_C   = (AW + 1)'(FIFO_DEPTH);
  localparam logic [CW-1:0] TIMEOUT_C = CW'(TIMEOUT);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_HOLD} state_t;

  state_t        r_state;
  state_t        w_state_next;

  // FIFO entry: {central, radius, mode, tag}
  logic [EW-1:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic [1:0]    r_wr_tag;
  logic          r_ovf;

  logic [23:0]   r_central;
  logic [11:0]   r_radius;
  logic [1:0]    r_mode;
  logic [1:0]    r_cur_tag;
  logic [CW-1:0] r_wait_cnt;

  logic          r_res_valid;
  logic [7:0]    r_res_candidate;
  logic [1:0]    r_res_tag;
  logic          r_res_err;

  logic          w_full;
  logic          w_wr_ok;
  logic          w_load_head;
  logic          w_en;
  logic          w_hit;
  logic          w_timeout;
  logic          w_accept;
  logic          w_pop;

  assign w_full  = (r_count == DEPTH_C);
  // a write while full is dropped even if the head is popped in the same cycle
  assign w_wr_ok = bus.cmd_wr && !w_full;
  assign w_pop   = w_hit || w_timeout;

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_next;
  end

  // FSM next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if ((r_count != '0) && !r_res_valid) w_state_next = S_ISSUE;
      S_ISSUE: w_state_next = S_WAIT;
      S_WAIT:  if (bus.set_valid || (r_wait_cnt >= TIMEOUT_C)) w_state_next = S_HOLD;
      S_HOLD:  if (r_res_valid && bus.res_ready) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // FSM outputs: start pulse, head load, result capture and accept strobes
  always_comb begin
    w_en        = 1'b0;
    w_load_head = 1'b0;
    w_hit       = 1'b0;
    w_timeout   = 1'b0;
    w_accept    = 1'b0;
    case (r_state)
      S_IDLE:  w_load_head = (r_count != '0) && !r_res_valid;
      S_ISSUE: w_en = 1'b1;
      S_WAIT: begin
        w_hit     = bus.set_valid;
        w_timeout = !bus.set_valid && (r_wait_cnt >= TIMEOUT_C);
      end
      S_HOLD:  w_accept = r_res_valid && bus.res_ready;
      default: ;
    endcase
  end

  // FIFO storage, no reset so it maps onto RAM
  always_ff @(posedge clk) begin
    if (w_wr_ok) r_mem[r_wr_ptr] <= {bus.cmd_central, bus.cmd_radius, bus.cmd_mode, r_wr_tag};
  end

  // FIFO pointers, occupancy, tag counter and sticky overflow flag
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_wr_tag <= '0;
      r_ovf    <= 1'b0;
    end else begin
      if (w_wr_ok) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
        r_wr_tag <= r_wr_tag + 1'b1;
      end
      if (bus.cmd_wr && w_full) r_ovf <= 1'b1;
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_wr_ok, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // registered read of the FIFO head; held stable until the next issue
  always_ff @(posedge clk) begin
    if (rst) begin
      r_central <= '0;
      r_radius  <= '0;
      r_mode    <= '0;
      r_cur_tag <= '0;
    end else if (w_load_head) begin
      {r_central, r_radius, r_mode, r_cur_tag} <= r_mem[r_rd_ptr];
    end
  end

  // wait counter: 1 in the first WAIT cycle, saturating so it never wraps
  always_ff @(posedge clk) begin
    if (rst)                                        r_wait_cnt <= '0;
    else if (w_en)                                  r_wait_cnt <= CW'(1);
    else if ((r_state == S_WAIT) && (r_wait_cnt != '1)) r_wait_cnt <= r_wait_cnt + 1'b1;
  end

  // result capture on engine strobe or timeout, released on accept
  always_ff @(posedge clk) begin
    if (rst) begin
      r_res_valid     <= 1'b0;
      r_res_candidate <= '0;
      r_res_tag       <= '0;
      r_res_err       <= 1'b0;
    end else if (w_pop) begin
      r_res_valid     <= 1'b1;
      r_res_candidate <= w_hit ? bus.set_candidate : 8'd0;
      r_res_tag       <= r_cur_tag;
      r_res_err       <= w_timeout;
    end else if (w_accept) begin
      r_res_valid     <= 1'b0;
    end
  end

  assign bus.cmd_full      = w_full;
  assign bus.cmd_ovf       = r_ovf;
  assign bus.en            = w_en;
  assign bus.central       = r_central;
  assign bus.radius        = r_radius;
  assign bus.mode          = r_mode;
  assign bus.res_valid     = r_res_valid;
  assign bus.res_candidate = r_res_candidate;
  assign bus.res_tag       = r_res_tag;
  assign bus.res_err       = r_res_err;

endmodule
